// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned JADDR_W = 26;

  localparam logic [OPC_W-1:0] J_OPCODE   = 6'b000010;
  localparam logic [OPC_W-1:0] JAL_OPCODE = 6'b000011;
  localparam logic [XLEN-1:0]  NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_BUF    = 2'd1,
    S_SQUASH = 2'd2
  } fetch_state_e;

  // Payload presented to the IF/ID register
  typedef struct packed {
    logic            valid;
    logic            jump;
    logic [XLEN-1:0] instn;
    logic [XLEN-1:0] nextpc;
    logic [XLEN-1:0] currpc;
  } if_out_t;

  // Response parked while ID is stalled
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instn;
  } skid_t;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Redirect target selection: EX branch beats ID jump; target is word aligned.
module fetch_redirect_mux (
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump_in,
  input  logic [25:0] jump_address,
  input  logic [31:0] jump_pc4,
  output logic        redirect_c,
  output logic [31:0] target_c
);
  import fetch_stage_pkg::*;

  logic [XLEN-1:0] raw_c;
  logic            unused_c;

  // Priority select, then clear the byte-offset bits
  always_comb begin
    raw_c = br_target;
    if (!br_taken) begin
      raw_c = {jump_pc4[31:28], jump_address, 2'b00};
    end
    target_c   = {raw_c[XLEN-1:2], 2'b00};
    redirect_c = br_taken | jump_in;
  end

  // Low bits of the inputs that never reach the target
  assign unused_c = ^{jump_pc4[27:0], br_target[1:0]};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake, one-entry skid buffer, redirect flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [5:0]  J_OPCODE   = 6'b000010,
  parameter logic [5:0]  JAL_OPCODE = 6'b000011
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump_in,
  input  logic [25:0] jump_address,
  input  logic [31:0] jump_pc4,
  output logic [31:0] currpc,
  output logic [31:0] nextpc,
  output logic [31:0] instn,
  output logic        jump_out,
  output logic        if_valid
);
  import fetch_stage_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] sq_addr_q, sq_addr_d;
  skid_t           skid_q, skid_d;
  if_out_t         out_q, out_d;

  logic            redirect_c;
  logic [XLEN-1:0] target_c;
  logic            accept_c;

  fetch_redirect_mux u_redirect (
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jump_in      (jump_in),
    .jump_address (jump_address),
    .jump_pc4     (jump_pc4),
    .redirect_c   (redirect_c),
    .target_c     (target_c)
  );

  // Build a valid IF/ID payload with the jump predecode
  function automatic if_out_t make_out(input logic [XLEN-1:0] pc,
                                       input logic [XLEN-1:0] word);
    if_out_t o;
    o.currpc = pc;
    o.nextpc = pc + XLEN'(4);
    o.instn  = word;
    o.jump   = (word[31:26] == J_OPCODE) || (word[31:26] == JAL_OPCODE);
    o.valid  = 1'b1;
    return o;
  endfunction

  // Request is dropped while buffered and in the reset cycle
  assign imem_req  = !reset && (state_q != S_BUF);
  assign imem_addr = (state_q == S_SQUASH) ? sq_addr_q : pc_q;
  assign accept_c  = imem_req && imem_ready;

  assign currpc   = out_q.currpc;
  assign nextpc   = out_q.nextpc;
  assign instn    = out_q.instn;
  assign jump_out = out_q.jump;
  assign if_valid = out_q.valid;

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      sq_addr_q <= RESET_PC;
      skid_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sq_addr_q <= sq_addr_d;
      skid_q    <= skid_d;
      out_q     <= out_d;
    end
  end

  // Next-state, next-PC and IF/ID payload; redirect overrides stall
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sq_addr_d = sq_addr_q;
    skid_d    = skid_q;
    out_d     = out_q;

    if (redirect_c) begin
      pc_d        = target_c;
      skid_d      = '0;
      out_d.valid = 1'b0;
      out_d.instn = NOP;
      out_d.jump  = 1'b0;
      if ((state_q == S_FETCH) && !accept_c) begin
        // Outstanding request must still complete at the old address
        state_d   = S_SQUASH;
        sq_addr_d = pc_q;
      end else if ((state_q == S_SQUASH) && !accept_c) begin
        state_d = S_SQUASH;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (accept_c) begin
            pc_d = pc_q + XLEN'(4);
            if (stall) begin
              skid_d.pc    = pc_q;
              skid_d.instn = imem_rdata;
              state_d      = S_BUF;
            end else begin
              out_d = make_out(pc_q, imem_rdata);
            end
          end else if (!stall) begin
            out_d.valid = 1'b0;
            out_d.instn = NOP;
            out_d.jump  = 1'b0;
          end
        end
        S_BUF: begin
          if (!stall) begin
            out_d   = make_out(skid_q.pc, skid_q.instn);
            skid_d  = '0;
            state_d = S_FETCH;
          end
        end
        S_SQUASH: begin
          if (accept_c) begin
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that drives the IF/ID pipeline register: PC register, instruction-memory request handshake, next-PC selection, stall skid buffering and flush on redirect.
- Produces currpc, nextpc (PC+4), instruction and a predecoded jump flag each time a fetch completes.
- Consumes jump redirects from ID, branch redirects from EX, and the stall from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- J_OPCODE, 6'b000010, opcode that sets the predecoded jump flag.
- JAL_OPCODE, 6'b000011, second opcode that sets the jump flag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  hazard unit: hold the IF outputs.
- br_taken  in  1  EX branch redirect.
- br_target  in  32  branch target.
- jump_in  in  1  ID jump redirect.
- jump_address  in  26  jump field from the ID-stage instruction.
- jump_pc4  in  32  PC+4 of the jump instruction in ID.
- currpc  out  32  PC of the presented instruction.
- nextpc  out  32  currpc+4.
- instn  out  32  instruction presented to IF/ID; 0 (NOP) when if_valid=0.
- jump_out  out  1  instn[31:26] equals J_OPCODE or JAL_OPCODE, gated by if_valid.
- if_valid  out  1  presented instruction is real, not a bubble.

Behaviour:
- Reset (synchronous) sets:
  - pc=RESET_PC; state=S_FETCH.
  - currpc=0, nextpc=0, instn=0, jump_out=0, if_valid=0.
  - Buffer is emptied.
  - imem_req drops in the reset cycle. Memory abandons any outstanding request under reset.
- "Accept" means imem_req && imem_ready in a cycle.
- Redirect target selection:
  - br_taken: br_target.
  - Otherwise jump_in: {jump_pc4[31:28], jump_address, 2'b00}.
  - br_taken has priority over jump_in.
  - Target bits [1:0] are forced to 0.
- Address arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
- S_FETCH:
  - imem_req=1, imem_addr=pc.
  - Accept with stall=0: outputs take {pc, pc+4, imem_rdata, predecode}, if_valid=1, pc<=pc+4. Back-to-back accepts give 1 instruction/cycle.
  - Accept with stall=1: outputs hold; response is written into the one-entry buffer; pc<=pc+4; go to S_BUF.
  - No accept with stall=1: outputs hold; imem_req stays high at the same address (no request withdrawal).
  - No accept with stall=0: if_valid<=0, instn<=0 (bubble).
- S_BUF:
  - imem_req=0.
  - When stall=0: outputs are loaded from the buffer with if_valid=1; go to S_FETCH.
  - While stall=1: hold.
- S_SQUASH:
  - imem_req=1 at the old address until accept. The response is discarded.
  - Then go to S_FETCH at the redirected pc.
- Redirect (br_taken or jump_in) in any state, evaluated before everything else:
  - pc<=target; buffer is emptied.
  - if_valid<=0, instn<=0, jump_out<=0 next cycle, even if stall=1. Flush beats stall.
  - If in S_FETCH without accept this cycle: go to S_SQUASH; the address register keeps the old address.
  - Otherwise go to S_FETCH. A same-cycle accept is discarded.
- Redirect while in S_SQUASH: retarget pc and stay in S_SQUASH.
- Redirect and reset together: reset wins.
- Output latency: a response accepted at edge N appears on the outputs after edge N, unless stalled.

Decomposition:
- Shared package holds:
  - Opcode constants J_OPCODE and JAL_OPCODE.
  - State encodings S_FETCH, S_BUF, S_SQUASH (2-bit).
  - NOP word 32'h0.
- One sub-module, fetch_redirect_mux: combinational target selection, priority and alignment. Everything else is in fetch_stage.

Test Plan:
- Reset release with imem_ready=1 constant and memory word = address: first accept at pc=0; on the following cycles currpc=0,4,8 with nextpc=4,8,12, instn equal to the address, and if_valid=1 on each.
- stall=1 on the cycle an accept at pc=0x10 occurs, held 3 cycles:
  - Outputs hold the 0x0C instruction; imem_req=0 while buffered.
  - After stall drops, currpc=0x10 and the next request is at 0x14.
- jump_in=1, jump_address=26'h0000040, jump_pc4=0x1000_0008 → next fetch address 0x1000_0100; one bubble (if_valid=0, instn=0).
- br_taken=1 (br_target=0x200) and jump_in=1 in the same cycle, with stall=1 → fetch at 0x200; if_valid=0 despite the stall.
- imem_ready held 0 for 4 cycles at pc=0x40, redirect to 0x80 in cycle 2:
  - imem_addr stays 0x40 until accept; that data is discarded.
  - Next request is at 0x80; instruction 0x40 never appears with if_valid=1.
- pc=0xFFFF_FFFC accept → nextpc=0, next fetch at 0. Assert reset mid-S_BUF → all outputs 0 and pc=RESET_PC next cycle.
